// File: rtl/vga_pkg.sv
// Shared VGA definitions: timing presets, pixel colour type, sync region helper.
package vga_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock)
  localparam int unsigned VGA640_H_VISIBLE = 640;
  localparam int unsigned VGA640_H_FRONT   = 16;
  localparam int unsigned VGA640_H_SYNC    = 96;
  localparam int unsigned VGA640_H_BACK    = 48;
  localparam int unsigned VGA640_V_VISIBLE = 480;
  localparam int unsigned VGA640_V_FRONT   = 10;
  localparam int unsigned VGA640_V_SYNC    = 2;
  localparam int unsigned VGA640_V_BACK    = 33;

  // 1024x768 @ 60 Hz (65 MHz pixel clock)
  localparam int unsigned VGA1024_H_VISIBLE = 1024;
  localparam int unsigned VGA1024_H_FRONT   = 24;
  localparam int unsigned VGA1024_H_SYNC    = 136;
  localparam int unsigned VGA1024_H_BACK    = 160;
  localparam int unsigned VGA1024_V_VISIBLE = 768;
  localparam int unsigned VGA1024_V_FRONT   = 3;
  localparam int unsigned VGA1024_V_SYNC    = 6;
  localparam int unsigned VGA1024_V_BACK    = 29;

  localparam int unsigned RGB_COLOR_W = 8;

  typedef struct packed {
    logic [RGB_COLOR_W-1:0] r;
    logic [RGB_COLOR_W-1:0] g;
    logic [RGB_COLOR_W-1:0] b;
  } rgb_t;

  // True while cnt lies inside the sync pulse [vis+front, vis+front+sync)
  function automatic logic sync_region(input int unsigned cnt,
                                       input int unsigned vis,
                                       input int unsigned front,
                                       input int unsigned sync);
    return (cnt >= vis + front) && (cnt < vis + front + sync);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter advanced on ce && inc, with region flags.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VIS   = 1024,
  parameter int unsigned FRONT = 24,
  parameter int unsigned SYNC  = 136,
  parameter int unsigned BACK  = 160,
  parameter int unsigned W     = $clog2(VIS + FRONT + SYNC + BACK)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         visible,
  output logic         in_sync
);

  localparam int unsigned TOTAL = VIS + FRONT + SYNC + BACK;

  assign wrap    = inc && (cnt == W'(TOTAL - 1));
  assign visible = 32'(cnt) < VIS;
  assign in_sync = sync_region(32'(cnt), VIS, FRONT, SYNC);

  // Count 0..TOTAL-1 on qualified increments, wrapping to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ce && inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster engine: pixel request stage, PIPE_DELAY alignment line, sync/RGB output stage.
// Optional feature macro: VGA_TEST_PATTERN_EN (8 vertical colour bars selected by test_en).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = 1024,
  parameter int unsigned H_FRONT    = 24,
  parameter int unsigned H_SYNC     = 136,
  parameter int unsigned H_BACK     = 160,
  parameter int unsigned V_VISIBLE  = 768,
  parameter int unsigned V_FRONT    = 3,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BACK     = 29,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DELAY = 4,
  parameter int unsigned COLOR_W    = 8,
  localparam int unsigned H_LINE    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_FRAME   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned XW        = $clog2(H_LINE),
  localparam int unsigned YW        = $clog2(V_FRAME)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_ce,
  input  logic                 test_en,
  input  logic [3*COLOR_W-1:0] color_in,
  output logic                 active,
  output logic [XW-1:0]        active_x,
  output logic [YW-1:0]        active_y,
  output logic                 screenend,
  output logic                 hsync,
  output logic                 vsync,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue
);

  // Delay-line word layout: {[bar index,] active, hsync_raw, vsync_raw}
  localparam int unsigned P_VS  = 0;
  localparam int unsigned P_HS  = 1;
  localparam int unsigned P_ACT = 2;
`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned PW = 6;
`else
  localparam int unsigned PW = 3;
`endif

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_wrap, h_vis, h_in_sync;
  logic          v_wrap_unused, v_vis, v_in_sync;
  logic          hsync_raw, vsync_raw;
  logic [PW-1:0] pipe_in, pipe_tap;
  logic [3*COLOR_W-1:0] color_src;

  vga_axis_counter #(
    .VIS   (H_VISIBLE),
    .FRONT (H_FRONT),
    .SYNC  (H_SYNC),
    .BACK  (H_BACK),
    .W     (XW)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .ce      (pix_ce),
    .inc     (1'b1),
    .cnt     (h_cnt),
    .wrap    (h_wrap),
    .visible (h_vis),
    .in_sync (h_in_sync)
  );

  vga_axis_counter #(
    .VIS   (V_VISIBLE),
    .FRONT (V_FRONT),
    .SYNC  (V_SYNC),
    .BACK  (V_BACK),
    .W     (YW)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .ce      (pix_ce),
    .inc     (h_wrap),
    .cnt     (v_cnt),
    .wrap    (v_wrap_unused),
    .visible (v_vis),
    .in_sync (v_in_sync)
  );

  // Request stage: register the current raster position and its region flags
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      active_x  <= '0;
      active_y  <= '0;
      screenend <= 1'b0;
      hsync_raw <= 1'b0;
      vsync_raw <= 1'b0;
    end else if (pix_ce) begin
      active    <= h_vis && v_vis;
      active_x  <= h_cnt;
      active_y  <= v_cnt;
      screenend <= (h_cnt == XW'(H_VISIBLE - 1)) && (v_cnt == YW'(V_VISIBLE - 1));
      hsync_raw <= h_in_sync;
      vsync_raw <= v_in_sync;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;

  // Bar index from the requested column, carried down the delay line with its pixel
  always_comb begin
    bar_idx = 3'((32'(active_x) * 8) / H_VISIBLE);
  end

  assign pipe_in = {bar_idx, active, hsync_raw, vsync_raw};

  // Colour source: internal bars while test_en, else the frame source
  always_comb begin
    color_src = color_in;
    if (test_en) begin
      color_src = {{COLOR_W{pipe_tap[5]}}, {COLOR_W{pipe_tap[4]}}, {COLOR_W{pipe_tap[3]}}};
    end
  end
`else
  logic unused_test_en;
  assign unused_test_en = test_en;

  assign pipe_in = {active, hsync_raw, vsync_raw};

  // Colour source: the frame source only
  always_comb begin
    color_src = color_in;
  end
`endif

  // With zero delay the output register samples the request stage directly
  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign pipe_tap = pipe_in;
    end else begin : g_delay
      logic [PW-1:0] dl [PIPE_DELAY];

      // Shift register matching the frame source's colour latency
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
            dl[i] <= '0;
          end
        end else if (pix_ce) begin
          dl[0] <= pipe_in;
          for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
            dl[i] <= dl[i-1];
          end
        end
      end

      assign pipe_tap = dl[PIPE_DELAY-1];
    end
  endgenerate

  // Output stage: apply sync polarity and blank RGB outside the visible area
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= ~H_SYNC_POL;
      vsync <= ~V_SYNC_POL;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pix_ce) begin
      hsync <= pipe_tap[P_HS] ? H_SYNC_POL : ~H_SYNC_POL;
      vsync <= pipe_tap[P_VS] ? V_SYNC_POL : ~V_SYNC_POL;
      red   <= pipe_tap[P_ACT] ? color_src[3*COLOR_W-1 -: COLOR_W] : '0;
      green <= pipe_tap[P_ACT] ? color_src[2*COLOR_W-1 -: COLOR_W] : '0;
      blue  <= pipe_tap[P_ACT] ? color_src[COLOR_W-1 -: COLOR_W]   : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in the small 14x7 configuration, PIPE_DELAY = 2.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b1;
  logic        test_en = 1'b0;
  logic [23:0] color_in = 24'h0000A5;
  logic        active;
  logic [3:0]  active_x;
  logic [2:0]  active_y;
  logic        screenend, hsync, vsync;
  logic [7:0]  red, green, blue;

  int checks = 0;
  int errors = 0;
  // Number of ce edges since reset released; 0 means reset state
  int n = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE  (8),
    .H_FRONT    (2),
    .H_SYNC     (2),
    .H_BACK     (2),
    .V_VISIBLE  (4),
    .V_FRONT    (1),
    .V_SYNC     (1),
    .V_BACK     (1),
    .H_SYNC_POL (1'b0),
    .V_SYNC_POL (1'b0),
    .PIPE_DELAY (2),
    .COLOR_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_ce    (pix_ce),
    .test_en   (test_en),
    .color_in  (color_in),
    .active    (active),
    .active_x  (active_x),
    .active_y  (active_y),
    .screenend (screenend),
    .hsync     (hsync),
    .vsync     (vsync),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame source: colour for the request made two ce edges earlier (pixel index m-3)
  function automatic logic [23:0] color_for(input int m);
    int p;
    if (m < 3) return 24'h0000A5;
    p = m - 3;
    return {8'(p % 14), 8'((p / 14) % 7), 8'hA5};
  endfunction

  // Expected outputs from the ce-edge count: request shows pixel n-1, output shows pixel n-4
  task automatic check_model();
    int p, q, ox, oy;
    logic [2:0]  b;
    logic [23:0] exp_rgb;
    if (n == 0) begin
      chk("req_active", active, 0);
      chk("req_x", active_x, 0);
      chk("req_y", active_y, 0);
      chk("screenend", screenend, 0);
    end else begin
      p = n - 1;
      chk("req_active", active, ((p % 14) < 8) && (((p / 14) % 7) < 4));
      chk("req_x", active_x, p % 14);
      chk("req_y", active_y, (p / 14) % 7);
      chk("screenend", screenend, (p % 98) == 49);
    end
    if (n < 4) begin
      chk("hsync", hsync, 1);
      chk("vsync", vsync, 1);
      chk("rgb", {red, green, blue}, 0);
    end else begin
      q  = n - 4;
      ox = q % 14;
      oy = (q / 14) % 7;
      chk("hsync", hsync, !(ox >= 10 && ox < 12));
      chk("vsync", vsync, !(oy == 5));
      exp_rgb = 24'h0;
      if (ox < 8 && oy < 4) begin
        exp_rgb = {8'(ox), 8'(oy), 8'hA5};
`ifdef VGA_TEST_PATTERN_EN
        if (test_en) begin
          b = 3'(ox);
          exp_rgb = {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        end
`endif
      end
      chk("rgb", {red, green, blue}, exp_rgb);
    end
  endtask

  task automatic tick(input logic ce, input logic r);
    pix_ce = ce;
    rst    = r;
    @(posedge clk);
    #1;
    if (r) n = 0;
    else if (ce) n++;
    color_in = color_for(n);
    check_model();
  endtask

  int hs_low, vs_low, se_cnt, act_cnt, se_rise;
  logic se_prev;

  initial begin
    // Reset held three clocks with pix_ce high
    repeat (3) tick(1'b1, 1'b1);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_active", active, 0);

    // First ce edge after release requests (0,0)
    tick(1'b1, 1'b0);
    chk("first_active", active, 1);
    chk("first_x", active_x, 0);
    chk("first_y", active_y, 0);

    // hsync falls three clocks after the x=10 request
    while (n < 11) tick(1'b1, 1'b0);
    chk("req_x10", active_x, 10);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("hs_before", hsync, 1);
    tick(1'b1, 1'b0);
    chk("hs_start", hsync, 0);
    tick(1'b1, 1'b0);
    chk("hs_second", hsync, 0);
    tick(1'b1, 1'b0);
    chk("hs_end", hsync, 1);

    // One full line: 2 hsync-low clocks
    hs_low = 0;
    repeat (14) begin
      tick(1'b1, 1'b0);
      if (!hsync) hs_low++;
    end
    chk("line_hs_low", hs_low, 2);

    // One full frame window of 98 clocks
    while (n < 98) tick(1'b1, 1'b0);
    hs_low = 0; vs_low = 0; se_cnt = 0; act_cnt = 0;
    repeat (98) begin
      tick(1'b1, 1'b0);
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (screenend) se_cnt++;
      if (active) act_cnt++;
    end
    chk("frame_hs_low", hs_low, 14);
    chk("frame_vs_low", vs_low, 14);
    chk("frame_screenend", se_cnt, 1);
    chk("frame_active", act_cnt, 32);

    // Alternating pix_ce: one frame over 196 clocks, outputs hold on ce=0 edges;
    // test_en is raised to show it has no effect in the default build
    test_en = 1'b1;
    vs_low = 0; se_cnt = 0; se_rise = 0; se_prev = screenend;
    repeat (98) begin
      tick(1'b1, 1'b0);
      if (!vsync) vs_low++;
      if (screenend) se_cnt++;
      if (screenend && !se_prev) se_rise++;
      se_prev = screenend;
      tick(1'b0, 1'b0);
      if (!vsync) vs_low++;
      if (screenend) se_cnt++;
      se_prev = screenend;
    end
    chk("ce_vs_low_clks", vs_low, 28);
    chk("ce_screenend_clks", se_cnt, 2);
    chk("ce_screenend_pulses", se_rise, 1);
    test_en = 1'b0;

    // Mid-frame reset at (5,2), asserted with pix_ce low to show rst priority
    while (((n - 1) % 98) != 33) tick(1'b1, 1'b0);
    chk("pre_rst_x", active_x, 5);
    chk("pre_rst_y", active_y, 2);
    tick(1'b0, 1'b1);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_hsync", hsync, 1);
    tick(1'b1, 1'b0);
    chk("restart_x", active_x, 0);
    chk("restart_y", active_y, 0);
    chk("restart_active", active, 1);
    while (n < 20) tick(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
